// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// FSM state encoding and address field positions.
package dcache_ctrl_pkg;

   localparam int unsigned LINE_WORDS  = 4;
   localparam int unsigned OFFSET_BITS = 3;
   localparam int unsigned WORD_LSB    = 1;
   localparam int unsigned WORD_BITS   = 2;
   localparam int unsigned IDX_LSB     = OFFSET_BITS;
   localparam int unsigned RCV_BITS    = 3;

   typedef enum logic [2:0] {
      IDLE,
      WRBACK,
      ALLOC,
      FILL,
      DONE
   } state_e;

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundle of pipeline-side request/response and main-memory signals; the cache
// is the slave of the pipeline and master of memory, the bench uses the other view.
interface dcache_ctrl_if;

   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic        Rd;
   logic        Wr;
   logic [15:0] DataOut;
   logic        Done;
   logic        Stall;
   logic        CacheHit;
   logic        err;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_wr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;

   modport slave (
      input  Addr, DataIn, Rd, Wr, mem_rdata, mem_rvalid,
      output DataOut, Done, Stall, CacheHit, err,
             mem_addr, mem_wdata, mem_wr, mem_rd
   );

   modport master (
      output Addr, DataIn, Rd, Wr, mem_rdata, mem_rvalid,
      input  DataOut, Done, Stall, CacheHit, err,
             mem_addr, mem_wdata, mem_wr, mem_rd
   );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one synchronous
// write port (word write and/or tag install); rst clears all valid and dirty bits.
module dcache_array
   import dcache_ctrl_pkg::*;
#(
   parameter int unsigned IDX_BITS = 5,
   parameter int unsigned TAG_BITS = 16 - OFFSET_BITS - IDX_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_BITS-1:0]  rd_idx,
   input  logic [WORD_BITS-1:0] rd_word,
   output logic [15:0]          rd_data,
   output logic [TAG_BITS-1:0]  rd_tag,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   input  logic                 wr_en,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic [WORD_BITS-1:0] wr_word,
   input  logic [15:0]          wr_data,
   input  logic                 wr_dirty,
   input  logic                 inst_en,
   input  logic [TAG_BITS-1:0]  inst_tag
);

   localparam int unsigned LINES = 1 << IDX_BITS;

   logic [15:0]         data_q  [LINES][LINE_WORDS];
   logic [15:0]         data_d  [LINES][LINE_WORDS];
   logic [TAG_BITS-1:0] tag_q   [LINES];
   logic [TAG_BITS-1:0] tag_d   [LINES];
   logic [LINES-1:0]    valid_q, valid_d;
   logic [LINES-1:0]    dirty_q, dirty_d;

   assign rd_data  = data_q[rd_idx][rd_word];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (wr_en) begin
         data_d[wr_idx][wr_word] = wr_data;
         if (wr_dirty) dirty_d[wr_idx] = 1'b1;
      end
      // A fill's last word and the tag install land in the same cycle.
      if (inst_en) begin
         tag_d[wr_idx]   = inst_tag;
         valid_d[wr_idx] = 1'b1;
         dirty_d[wr_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller producing the
// memory-stage stall and sequencing victim writeback and line fill.
module dcache_ctrl
   import dcache_ctrl_pkg::*;
#(
   parameter int unsigned IDX_BITS = 5,
   parameter int unsigned TAG_BITS = 16 - OFFSET_BITS - IDX_BITS
) (
   input logic          clk,
   input logic          rst,
   dcache_ctrl_if.slave bus
);

   localparam int unsigned TAG_LSB = IDX_LSB + IDX_BITS;

   state_e               state_q, state_d;
   logic [WORD_BITS-1:0] cnt_q, cnt_d;
   logic [RCV_BITS-1:0]  rcv_q, rcv_d;
   logic                 ign_rv_q, ign_rv_d;
   logic [TAG_BITS-1:0]  lat_tag_q, lat_tag_d;
   logic [IDX_BITS-1:0]  lat_idx_q, lat_idx_d;
   logic [WORD_BITS-1:0] lat_word_q, lat_word_d;
   logic [15:0]          lat_data_q, lat_data_d;
   logic                 lat_wr_q, lat_wr_d;

   logic [TAG_BITS-1:0]  req_tag;
   logic [IDX_BITS-1:0]  req_idx;
   logic [WORD_BITS-1:0] req_word;
   logic                 req, bad;

   logic [IDX_BITS-1:0]  arr_idx, wr_idx;
   logic [WORD_BITS-1:0] arr_word, wr_word;
   logic [15:0]          arr_data, wr_data;
   logic [TAG_BITS-1:0]  arr_tag;
   logic                 arr_valid, arr_dirty;
   logic                 wr_en, wr_dirty, inst_en;

   logic                 done, stall, hit_o, err_o, mem_wr, mem_rd;
   logic [15:0]          data_out, mem_addr, mem_wdata;

   assign req_tag  = bus.Addr[TAG_LSB +: TAG_BITS];
   assign req_idx  = bus.Addr[IDX_LSB +: IDX_BITS];
   assign req_word = bus.Addr[WORD_LSB +: WORD_BITS];
   assign req      = bus.Rd | bus.Wr;
   assign bad      = (bus.Rd & bus.Wr) | (req & bus.Addr[0]);

   dcache_array #(
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (arr_idx),
      .rd_word  (arr_word),
      .rd_data  (arr_data),
      .rd_tag   (arr_tag),
      .rd_valid (arr_valid),
      .rd_dirty (arr_dirty),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_word  (wr_word),
      .wr_data  (wr_data),
      .wr_dirty (wr_dirty),
      .inst_en  (inst_en),
      .inst_tag (lat_tag_q)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rcv_d      = rcv_q;
      ign_rv_d   = ign_rv_q;
      lat_tag_d  = lat_tag_q;
      lat_idx_d  = lat_idx_q;
      lat_word_d = lat_word_q;
      lat_data_d = lat_data_q;
      lat_wr_d   = lat_wr_q;
      arr_idx    = lat_idx_q;
      arr_word   = lat_word_q;
      wr_en      = 1'b0;
      wr_idx     = lat_idx_q;
      wr_word    = lat_word_q;
      wr_data    = lat_data_q;
      wr_dirty   = 1'b0;
      inst_en    = 1'b0;
      done       = 1'b0;
      stall      = 1'b0;
      hit_o      = 1'b0;
      err_o      = 1'b0;
      data_out   = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wr     = 1'b0;
      mem_rd     = 1'b0;

      // Returns are counted in issue order; the 4th installs the line.
      if (bus.mem_rvalid) begin
         if ((state_q inside {ALLOC, FILL}) && (rcv_q != RCV_BITS'(LINE_WORDS))) begin
            wr_en   = 1'b1;
            wr_word = rcv_q[WORD_BITS-1:0];
            wr_data = bus.mem_rdata;
            inst_en = (rcv_q == RCV_BITS'(LINE_WORDS - 1));
            rcv_d   = rcv_q + 1'b1;
         end else if (!ign_rv_q) begin
            err_o = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            arr_idx  = req_idx;
            arr_word = req_word;
            if (bad) begin
               err_o = 1'b1;
            end else if (req) begin
               if (arr_valid && (arr_tag == req_tag)) begin
                  done     = 1'b1;
                  hit_o    = 1'b1;
                  data_out = arr_data;
                  if (bus.Wr) begin
                     wr_en    = 1'b1;
                     wr_idx   = req_idx;
                     wr_word  = req_word;
                     wr_data  = bus.DataIn;
                     wr_dirty = 1'b1;
                  end
               end else begin
                  stall      = 1'b1;
                  lat_tag_d  = req_tag;
                  lat_idx_d  = req_idx;
                  lat_word_d = req_word;
                  lat_data_d = bus.DataIn;
                  lat_wr_d   = bus.Wr;
                  cnt_d      = '0;
                  rcv_d      = '0;
                  state_d    = (arr_valid && arr_dirty) ? WRBACK : ALLOC;
               end
            end
         end
         WRBACK: begin
            stall     = 1'b1;
            arr_word  = cnt_q;
            mem_wr    = 1'b1;
            mem_addr  = {arr_tag, lat_idx_q, cnt_q, 1'b0};
            mem_wdata = arr_data;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == WORD_BITS'(LINE_WORDS - 1)) state_d = ALLOC;
         end
         ALLOC: begin
            stall    = 1'b1;
            mem_rd   = 1'b1;
            mem_addr = {lat_tag_q, lat_idx_q, cnt_q, 1'b0};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == WORD_BITS'(LINE_WORDS - 1)) state_d = FILL;
         end
         FILL: begin
            stall = 1'b1;
            if (rcv_d == RCV_BITS'(LINE_WORDS)) state_d = DONE;
         end
         DONE: begin
            done     = 1'b1;
            data_out = arr_data;
            if (lat_wr_q) begin
               wr_en    = 1'b1;
               wr_dirty = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Returns still in flight from before a reset are dropped until a new fill starts.
      if ((state_d == ALLOC) && (state_q != ALLOC)) ign_rv_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rcv_q      <= '0;
         ign_rv_q   <= 1'b1;
         lat_tag_q  <= '0;
         lat_idx_q  <= '0;
         lat_word_q <= '0;
         lat_data_q <= '0;
         lat_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rcv_q      <= rcv_d;
         ign_rv_q   <= ign_rv_d;
         lat_tag_q  <= lat_tag_d;
         lat_idx_q  <= lat_idx_d;
         lat_word_q <= lat_word_d;
         lat_data_q <= lat_data_d;
         lat_wr_q   <= lat_wr_d;
      end
   end

   assign bus.DataOut   = data_out;
   assign bus.Done      = done;
   assign bus.Stall     = stall;
   assign bus.CacheHit  = hit_o;
   assign bus.err       = err_o;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_wr    = mem_wr;
   assign bus.mem_rd    = mem_rd;

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller. It sits directly downstream of the memory stage's request, between the memory pipeline stage and the banked main memory. It produces the data-memory stall that freezes the ex/mem and mem/wb registers, and it owns the tag, valid and dirty state and the line fill/writeback sequencing.

Parameters:
IDX_BITS, 5, index width (2^IDX_BITS lines, 4 x 16-bit words per line)
TAG_BITS, 16-3-IDX_BITS, derived tag width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
Addr  in  16  byte address of request
DataIn  in  16  store data
Rd  in  1  load request
Wr  in  1  store request
DataOut  out  16  load data, valid when Done=1
Done  out  1  request complete this cycle
Stall  out  1  pipeline must hold (feeds en=~Stall)
CacheHit  out  1  Done was a hit
err  out  1  illegal request this cycle
mem_addr  out  16  main-memory word address
mem_wdata  out  16  writeback data
mem_wr  out  1  one-cycle word write strobe
mem_rd  out  1  one-cycle word read strobe
mem_rdata  in  16  returned read data
mem_rvalid  in  1  mem_rdata valid; returns arrive in issue order

Behaviour:
- Address split: Addr[2:1] = word offset, Addr[2+IDX_BITS:3] = index, upper bits = tag. Addr[0] must be 0.
- Reset (sync, also mid-operation): state=IDLE; all valid and dirty bits cleared; counters cleared. Done, Stall, CacheHit, err, mem_rd and mem_wr are all 0 in the cycle after reset. mem_rvalid is ignored until a new ALLOC.
- err=1 when (Rd&Wr) or ((Rd|Wr)&Addr[0]) while in IDLE. The request is ignored that cycle: no state change, Done=0, Stall=0.
- States: IDLE, WRBACK, ALLOC, FILL, DONE.
- IDLE, hit (valid and tag match):
  - Done=1, CacheHit=1 and Stall=0 in the same cycle; DataOut is combinational from the array.
  - On a Wr hit, the word is written and dirty set at the clock edge.
- IDLE, miss:
  - Stall=1, Done=0; Addr, DataIn and Wr are latched, and later input changes are ignored.
  - Next state is WRBACK if the victim is valid&dirty, else ALLOC.
- WRBACK: 4 cycles, word counter 0..3.
  - mem_wr=1 each cycle; mem_addr = {victim tag, index, cnt, 0}; mem_wdata = victim word cnt.
  - Then ALLOC.
- ALLOC: 4 cycles, mem_rd=1 each cycle, mem_addr = {latched tag, index, cnt, 0}, then FILL.
  - Arrivals (mem_rvalid) may start during ALLOC. A receive counter writes arrival k into word k.
- FILL: wait until 4 arrivals are received.
  - The cycle the 4th arrives: tag is installed, valid=1, dirty=0; next state DONE.
- DONE: 1 cycle. Done=1, CacheHit=0, Stall=0; DataOut = latched word.
  - If the latched op is Wr, the word is written and dirty set.
  - Next state IDLE. A new request is accepted in IDLE only, never in DONE.
- Stall=1 in WRBACK, ALLOC, FILL, and in the IDLE miss cycle. Otherwise Stall=0.
- Latency with a 2-cycle memory model (request = cycle 0):
  - hit: Done at cycle 0
  - clean miss: Done at cycle 7
  - dirty miss: Done at cycle 11
- Extra mem_rvalid beyond 4, or any mem_rvalid outside ALLOC/FILL, sets err=1 for that cycle and the data is discarded.
- Outputs default to 0 when not driven by a state: DataOut=0, mem_addr=0, mem_wdata=0.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE, WRBACK, ALLOC, FILL, DONE)
  - LINE_WORDS=4
  - OFFSET_BITS=3
  - field-extract constants for tag/index/offset
- One sub-module, dcache_array: tag/valid/dirty/data storage.
  - One combinational read port (index, word).
  - One synchronous write port: word write, tag install, dirty/valid set, clear-all on rst.

Test Plan:
1. After reset, Rd Addr=0x0010 → Stall=1 in cycle 0. mem_rd at cycles 1-4 with mem_addr 0x0010, 0x0012, 0x0014, 0x0016. Done=1, CacheHit=0 at cycle 7, DataOut=model[0x0010].
2. Following Rd Addr=0x0012 → Done=1, CacheHit=1, Stall=0 in the same cycle; DataOut=model[0x0012]; no mem_rd/mem_wr.
3. Wr 0x0012 data=0xBEEF (hit), then Rd 0x0112 (same index, new tag):
   - mem_wr cycles 1-4 to 0x0010..0x0016, with 0xBEEF at 0x0012
   - then 4 mem_rd to 0x0110..0x0116
   - Done at cycle 11, CacheHit=0
4. Rd=Wr=1 at 0x0020 → err=1, Done=0, Stall=0, no memory traffic. Rd at Addr=0x0021 → err=1. A subsequent Rd 0x0020 is a normal miss.
5. rst asserted during the 2nd ALLOC cycle → next cycle: Stall=0, mem_rd=0, state IDLE. Late mem_rvalid pulses are ignored (err=0). Rd to the same address misses again.
6. Wr miss to 0x0200 data=0x1234 on a clean line:
   - no mem_wr; fill completes; Done in DONE; line dirty
   - a later conflicting Rd 0x0300 produces mem_wr of 0x1234 at mem_addr 0x0200
